// File: rtl/reg_bank_encapsulation_pkg.sv
// Shared constants and types for the ARMv4 general register bank:
// register indices, IR field positions and the PC fetch increment.
package reg_bank_encapsulation_pkg;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned REG_W    = 32;
    localparam int unsigned IDX_W    = 4;

    typedef logic [IDX_W-1:0] reg_idx_t;
    typedef logic [REG_W-1:0] word_t;

    localparam reg_idx_t REG_SP = 4'd13;
    localparam reg_idx_t REG_LR = 4'd14;
    localparam reg_idx_t REG_PC = 4'd15;

    localparam int unsigned RN_HI = 19;
    localparam int unsigned RN_LO = 16;
    localparam int unsigned RD_HI = 15;
    localparam int unsigned RD_LO = 12;
    localparam int unsigned RS_HI = 11;
    localparam int unsigned RS_LO = 8;
    localparam int unsigned RM_HI = 3;
    localparam int unsigned RM_LO = 0;

    localparam word_t PC_INCREMENT = 32'd4;

    // Every register field in the IR is four bits wide, so only the low bit is needed.
    function automatic reg_idx_t ir_field(input word_t ir, input int unsigned lo);
        return ir[lo +: IDX_W];
    endfunction

endpackage

// File: rtl/reg_bank_encapsulation_if.sv
// Control word, instruction and point-to-point data buses between the
// state machine / datapath (master) and the register bank (slave).
interface reg_bank_encapsulation_if;
    import reg_bank_encapsulation_pkg::*;

    logic     LATCH_REG;
    logic     IR_RD_MUX;
    logic     LSM_RD_MUX;
    logic     RD_MUX;
    logic     PC_MUX;
    logic     DATA_MUX;
    logic     REG_GATE_B;
    logic     REG_GATE_C;
    word_t    IR;
    word_t    ALU_BUS;
    reg_idx_t REG_COUNTER;
    word_t    A_BUS;
    word_t    ST;
    word_t    PC;

    modport master (
        output LATCH_REG, IR_RD_MUX, LSM_RD_MUX, RD_MUX, PC_MUX, DATA_MUX,
        output REG_GATE_B, REG_GATE_C, IR, ALU_BUS, REG_COUNTER,
        input  A_BUS, ST, PC
    );

    modport slave (
        input  LATCH_REG, IR_RD_MUX, LSM_RD_MUX, RD_MUX, PC_MUX, DATA_MUX,
        input  REG_GATE_B, REG_GATE_C, IR, ALU_BUS, REG_COUNTER,
        output A_BUS, ST, PC
    );

endinterface

// File: rtl/reg_bank_encapsulation_reg_file_16x32.sv
// 16 x 32 register storage: three combinational read ports, fixed SP/PC taps,
// one write port and the PC fetch increment path.
module reg_file_16x32
    import reg_bank_encapsulation_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t rd_a_idx,
    input  reg_idx_t rd_b_idx,
    input  reg_idx_t rd_c_idx,
    input  logic     wr_en,
    input  reg_idx_t wr_idx,
    input  word_t    wr_data,
    input  logic     pc_inc,
    output word_t    rd_a_data,
    output word_t    rd_b_data,
    output word_t    rd_c_data,
    output word_t    sp_data,
    output word_t    pc_data
);

    word_t regs_q [NUM_REGS];
    word_t regs_d [NUM_REGS];

    // Write is applied after the increment so a latch into R15 overrides it.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (pc_inc) begin
            regs_d[REG_PC] = regs_q[REG_PC] + PC_INCREMENT;
        end
        if (wr_en) begin
            regs_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == int'(REG_PC)) ? RESET_PC : '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads see pre-edge contents; R15 is returned raw, without pipeline offset.
    assign rd_a_data = regs_q[rd_a_idx];
    assign rd_b_data = regs_q[rd_b_idx];
    assign rd_c_data = regs_q[rd_c_idx];
    assign sp_data   = regs_q[REG_SP];
    assign pc_data   = regs_q[REG_PC];

endmodule

// File: rtl/reg_bank_encapsulation.sv
// ARMv4 general register bank: IR field decode, destination/read index muxing,
// write-data selection and tri-state gating onto the shared B and C buses.
module reg_bank_encapsulation
    import reg_bank_encapsulation_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    reg_bank_encapsulation_if.slave  bus,
    output wire  [31:0]              B_BUS,
    output wire  [31:0]              C_BUS
);

    reg_idx_t rn_idx;
    reg_idx_t rd_idx;
    reg_idx_t rs_idx;
    reg_idx_t rm_idx;
    reg_idx_t dest_idx;
    reg_idx_t b_idx;
    word_t    wr_data;
    word_t    a_data;
    word_t    b_data;
    word_t    c_data;
    word_t    sp_data;
    word_t    pc_data;

    always_comb begin
        rn_idx = ir_field(bus.IR, RN_LO);
        rd_idx = ir_field(bus.IR, RD_LO);
        rs_idx = ir_field(bus.IR, RS_LO);
        rm_idx = ir_field(bus.IR, RM_LO);

        // Load/store-multiple sequencing takes precedence over the IR fields.
        if (bus.LSM_RD_MUX) begin
            dest_idx = bus.REG_COUNTER;
        end else if (bus.IR_RD_MUX) begin
            dest_idx = rn_idx;
        end else begin
            dest_idx = rd_idx;
        end

        b_idx   = bus.RD_MUX ? dest_idx : rm_idx;
        wr_data = bus.DATA_MUX ? pc_data : bus.ALU_BUS;
    end

    reg_file_16x32 #(
        .RESET_PC (RESET_PC)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .rd_a_idx  (rn_idx),
        .rd_b_idx  (b_idx),
        .rd_c_idx  (rs_idx),
        .wr_en     (bus.LATCH_REG),
        .wr_idx    (dest_idx),
        .wr_data   (wr_data),
        .pc_inc    (bus.PC_MUX),
        .rd_a_data (a_data),
        .rd_b_data (b_data),
        .rd_c_data (c_data),
        .sp_data   (sp_data),
        .pc_data   (pc_data)
    );

    assign bus.A_BUS = a_data;
    assign bus.ST    = sp_data;
    assign bus.PC    = pc_data;

    // B and C are shared with other units; release them whenever not gated.
    assign B_BUS = bus.REG_GATE_B ? b_data : 32'bz;
    assign C_BUS = bus.REG_GATE_C ? c_data : 32'bz;

endmodule

// File: tb/tb_reg_bank_encapsulation.sv
// Directed bench for reg_bank_encapsulation: reset, read ports, write paths,
// PC increment/override, link, LSM sequencing, wrap and asynchronous reset.
module tb_reg_bank_encapsulation;

    logic clk;
    logic rst;
    wire [31:0] b_bus;
    wire [31:0] c_bus;
    logic other_drv_b;
    logic other_drv_c;
    int checks;
    int errors;

    localparam logic [31:0] OTHER_B = 32'hA5A5_5A5A;
    localparam logic [31:0] OTHER_C = 32'h3C3C_C3C3;

    reg_bank_encapsulation_if bif ();

    reg_bank_encapsulation dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bif),
        .B_BUS (b_bus),
        .C_BUS (c_bus)
    );

    // Stand-in for another unit (e.g. the multiplier) sharing the buses.
    assign b_bus = other_drv_b ? OTHER_B : 32'bz;
    assign c_bus = other_drv_c ? OTHER_C : 32'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.LATCH_REG   = 1'b0;
        bif.IR_RD_MUX   = 1'b0;
        bif.LSM_RD_MUX  = 1'b0;
        bif.RD_MUX      = 1'b0;
        bif.PC_MUX      = 1'b0;
        bif.DATA_MUX    = 1'b0;
        bif.REG_GATE_B  = 1'b0;
        bif.REG_GATE_C  = 1'b0;
        bif.REG_COUNTER = 4'd0;
    endtask

    task automatic read_a(input logic [3:0] idx, input string tag, input logic [31:0] exp);
        bif.IR = {12'h000, idx, 16'h0000};
        #1;
        check(tag, bif.A_BUS, exp);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        other_drv_b = 1'b0;
        other_drv_c = 1'b0;
        rst         = 1'b0;
        idle();
        bif.IR      = 32'h0;
        bif.ALU_BUS = 32'h0;

        // Reset asserted mid-cycle, with garbage on the controls.
        #3;
        rst            = 1'b1;
        bif.LATCH_REG  = 1'bx;
        bif.PC_MUX     = 1'bx;
        bif.ALU_BUS    = 32'h1234_5678;
        #1;
        check("rst_pc", bif.PC, 32'h0);
        check("rst_st", bif.ST, 32'h0);
        check("rst_a", bif.A_BUS, 32'h0);
        other_drv_b = 1'b1;
        other_drv_c = 1'b1;
        #1;
        check("rst_b_released", b_bus, OTHER_B);
        check("rst_c_released", c_bus, OTHER_C);
        other_drv_b = 1'b0;
        other_drv_c = 1'b0;
        tick();
        tick();
        check("rst_hold_pc", bif.PC, 32'h0);
        idle();
        #2;
        rst = 1'b0;

        // Write R3 through the Rd field, then read it back on all three ports.
        bif.IR        = 32'h0000_3000;
        bif.ALU_BUS   = 32'hDEAD_BEEF;
        bif.LATCH_REG = 1'b1;
        tick();
        bif.LATCH_REG = 1'b0;
        read_a(4'd3, "a_r3", 32'hDEAD_BEEF);
        bif.IR         = 32'h0000_0003;
        bif.REG_GATE_B = 1'b1;
        #1;
        check("b_rm_r3", b_bus, 32'hDEAD_BEEF);
        bif.IR         = 32'h0000_0300;
        bif.REG_GATE_C = 1'b1;
        #1;
        check("c_rs_r3", c_bus, 32'hDEAD_BEEF);
        check("b_rm_r0_both_gates", b_bus, 32'h0);
        idle();
        other_drv_b = 1'b1;
        #1;
        check("b_released", b_bus, OTHER_B);
        other_drv_b = 1'b0;

        // No write-through: reads show pre-edge contents until the edge.
        bif.IR        = 32'h0003_3000;
        bif.ALU_BUS   = 32'h0000_0077;
        bif.LATCH_REG = 1'b1;
        #1;
        check("no_bypass_pre", bif.A_BUS, 32'hDEAD_BEEF);
        tick();
        check("no_bypass_post", bif.A_BUS, 32'h0000_0077);
        idle();

        // PC increments, then latch into R15 beats the increment.
        bif.PC_MUX = 1'b1;
        repeat (3) tick();
        check("pc_inc3", bif.PC, 32'h0000_000C);
        bif.IR        = 32'h0000_F000;
        bif.ALU_BUS   = 32'h0000_0100;
        bif.LATCH_REG = 1'b1;
        tick();
        check("pc_latch_wins", bif.PC, 32'h0000_0100);
        idle();
        tick();
        check("hold_pc", bif.PC, 32'h0000_0100);

        // BL link: R14 gets the current R15.
        bif.IR        = 32'h0000_F000;
        bif.ALU_BUS   = 32'h0000_0020;
        bif.LATCH_REG = 1'b1;
        tick();
        bif.IR       = 32'h0000_E000;
        bif.ALU_BUS  = 32'hFFFF_0000;
        bif.DATA_MUX = 1'b1;
        tick();
        idle();
        read_a(4'd14, "link_r14", 32'h0000_0020);
        check("link_pc_kept", bif.PC, 32'h0000_0020);

        // Destination from the Rn field writes the stack pointer.
        bif.IR        = 32'h000D_0000;
        bif.IR_RD_MUX = 1'b1;
        bif.ALU_BUS   = 32'h0000_8000;
        bif.LATCH_REG = 1'b1;
        tick();
        idle();
        check("st_r13", bif.ST, 32'h0000_8000);

        // Latch to another register and PC increment in the same edge.
        bif.IR        = 32'h0000_5000;
        bif.ALU_BUS   = 32'h0000_0055;
        bif.LATCH_REG = 1'b1;
        bif.PC_MUX    = 1'b1;
        tick();
        idle();
        check("both_pc", bif.PC, 32'h0000_0024);
        read_a(4'd5, "both_r5", 32'h0000_0055);

        // Load-multiple: REG_COUNTER selects the destination, ignoring Rd=7.
        bif.IR         = 32'h0000_7000;
        bif.LSM_RD_MUX = 1'b1;
        bif.LATCH_REG  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bif.REG_COUNTER = 4'(k);
            bif.ALU_BUS     = 32'(k * 16);
            tick();
        end
        bif.LATCH_REG   = 1'b0;
        bif.RD_MUX      = 1'b1;
        bif.REG_COUNTER = 4'd2;
        bif.REG_GATE_B  = 1'b1;
        #1;
        check("lsm_b_r2", b_bus, 32'h0000_0020);
        idle();
        read_a(4'd0, "lsm_r0", 32'h0000_0000);
        read_a(4'd1, "lsm_r1", 32'h0000_0010);
        read_a(4'd3, "lsm_r3", 32'h0000_0030);
        read_a(4'd7, "lsm_r7_untouched", 32'h0000_0000);

        // PC wrap at the top of the address space.
        bif.IR        = 32'h0000_F000;
        bif.ALU_BUS   = 32'hFFFF_FFFC;
        bif.LATCH_REG = 1'b1;
        tick();
        bif.LATCH_REG = 1'b0;
        bif.PC_MUX    = 1'b1;
        tick();
        check("pc_wrap", bif.PC, 32'h0000_0000);
        tick();
        idle();
        check("pc_after_wrap", bif.PC, 32'h0000_0004);

        // Asynchronous reset between edges clears everything at once.
        bif.IR = 32'h000E_0000;
        #1;
        rst = 1'b1;
        #1;
        check("async_pc", bif.PC, 32'h0);
        check("async_st", bif.ST, 32'h0);
        check("async_r14", bif.A_BUS, 32'h0);
        read_a(4'd3, "async_r3", 32'h0);
        tick();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_encapsulation.md
Name: reg_bank_encapsulation

Overview:
- 16 x 32-bit ARMv4 general register file (R0..R15, R15 = PC) with the IR field decode, port muxing and bus gating around it.
- Feeds the A bus (ALU operand / Rn) and drives the shared B and C buses through tri-state gates. Other units (e.g. the multiplier) share those buses.
- Writes back from the ALU bus or a link value, and increments the PC for instruction fetch.
- The block is controlled by control-word bits from the state machine.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into R15 on reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- LATCH_REG  in  1  write enable for the selected destination register
- IR_RD_MUX  in  1  destination field: 0 = IR[15:12], 1 = IR[19:16]
- LSM_RD_MUX  in  1  1 = destination index from REG_COUNTER (overrides IR_RD_MUX)
- RD_MUX  in  1  B-bus read index: 0 = Rm IR[3:0], 1 = current destination index
- PC_MUX  in  1  1 = increment PC by 4 on this edge
- DATA_MUX  in  1  write data: 0 = ALU_BUS, 1 = current R15 (link value)
- REG_GATE_B  in  1  drive B_BUS when 1, else high-Z
- REG_GATE_C  in  1  drive C_BUS when 1, else high-Z
- IR  in  32  instruction register
- ALU_BUS  in  32  ALU result
- REG_COUNTER  in  4  register index for load/store-multiple sequencing
- A_BUS  out  32  contents of Rn = R[IR[19:16]], always driven
- B_BUS  out  32  tri-state, R[B index] when gated
- C_BUS  out  32  tri-state, Rs = R[IR[11:8]] when gated
- ST  out  32  contents of R13 (stack pointer), always driven
- PC  out  32  contents of R15, always driven

Behaviour:
- Reset: asynchronous on rst high. R0..R14 = 0, R15 = RESET_PC, immediately and held while rst is high.
  - Output values under reset: A_BUS, ST, PC reflect the reset contents. B_BUS/C_BUS follow their gates.
- Destination index: LSM_RD_MUX ? REG_COUNTER : (IR_RD_MUX ? IR[19:16] : IR[15:12]).
- Write data: DATA_MUX ? R15 : ALU_BUS.
- Reads are combinational with zero latency. Reads return pre-edge contents; there is no write-through bypass.
- R15 reads return the raw register value, with no +8 pipeline adjustment.
- Rising edge with LATCH_REG=1: R[dest] <= write data.
- Rising edge with PC_MUX=1: R15 <= R15 + 4, 32-bit wrap (0xFFFF_FFFC -> 0).
- Simultaneous LATCH_REG with dest=15 and PC_MUX=1: the latch wins and R15 takes the write data.
- Simultaneous LATCH_REG to another register and PC_MUX: both occur.
- LATCH_REG=0 and PC_MUX=0: all registers hold.
- B_BUS and C_BUS are each 32'bz when their gate is 0. The bank never drives them otherwise.
- Both gates may be 1 together; each bus is independent.
- X on a control input during reset is ignored.
- No processor-mode banking or CPSR storage in this block.

Decomposition:
- Shared package: register index constants (REG_SP=13, REG_LR=14, REG_PC=15), IR field bit positions (RN_HI/LO 19:16, RD 15:12, RS 11:8, RM 3:0), and the PC_INCREMENT=4 constant.
- One natural sub-module, reg_file_16x32: the storage array with 3 combinational read ports (A, B, C), fixed R13/R15 taps, and one write port plus the PC increment path.
- The top level holds the index muxes, the data mux and the tri-state gates.

Test Plan:
- Reset with rst=1 mid-cycle: PC=0, ST=0, A_BUS=0 immediately. Both gates 0 -> B_BUS/C_BUS = Z.
- IR=32'h0000_3000, ALU_BUS=32'hDEAD_BEEF, LATCH_REG=1, other muxes 0, one edge -> R3=DEAD_BEEF.
  - Then IR=32'h0003_0000 -> A_BUS=DEAD_BEEF.
  - Then IR=32'h0000_0003, REG_GATE_B=1 -> B_BUS=DEAD_BEEF.
  - Then IR=32'h0000_0300, REG_GATE_C=1 -> C_BUS=DEAD_BEEF.
- PC_MUX=1 for 3 edges -> PC=0x0C.
  - Then LATCH_REG=1, dest R15 (IR=32'h0000_F000), ALU_BUS=0x100, PC_MUX=1 together -> PC=0x100, not 0x10.
- BL link: PC=0x20, IR=32'h0000_E000, DATA_MUX=1, LATCH_REG=1 -> R14=0x20. Also: IR_RD_MUX=1, IR=32'h000D_0000, ALU_BUS=0x8000 -> ST=0x8000.
- LSM: LSM_RD_MUX=1, REG_COUNTER steps 0..3 with ALU_BUS = 0x10*k, latching each cycle -> R0..R3 = 0,0x10,0x20,0x30, irrespective of the IR Rd field.
  - RD_MUX=1, REG_COUNTER=2, REG_GATE_B=1 -> B_BUS=0x20.
- Wrap/reset mid-op: load R15=0xFFFF_FFFC, PC_MUX=1 -> PC=0. Assert rst between edges -> all registers 0 asynchronously, before the next clk edge.
